// File: rtl/width_downsizer_pkg.sv
// Shared encodings for the width downsizer: per-word conversion modes and FSM states.
package width_downsizer_pkg;

  localparam int unsigned DEF_IN_W  = 32;
  localparam int unsigned DEF_OUT_W = 16;

  typedef enum logic [1:0] {
    MODE_TRUNC = 2'b00,
    MODE_SER   = 2'b01,
    MODE_SAT   = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/width_downsizer_sat_clamp.sv
// Combinational signed clamp of an IN_W-bit word into the OUT_W-bit signed range.
module width_downsizer_sat_clamp #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned OUT_W = 16
) (
  input  logic [IN_W-1:0]  data_i,
  output logic [OUT_W-1:0] value_c_o,
  output logic             sat_c_o
);

  localparam int unsigned UPPER_W = IN_W - OUT_W + 1;

  logic [UPPER_W-1:0] upper;
  logic               fits;

  // The word fits when every bit from the narrow sign bit upward equals the sign.
  always_comb begin
    upper     = data_i[IN_W-1:OUT_W-1];
    fits      = (upper == '0) || (upper == '1);
    value_c_o = data_i[OUT_W-1:0];
    sat_c_o   = 1'b0;
    if (!fits) begin
      sat_c_o   = 1'b1;
      value_c_o = data_i[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                 : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/width_downsizer.sv
// Registered IN_W -> OUT_W width converter with truncate, serialize and saturate modes
// and valid/ready handshakes on both sides.
module width_downsizer
  import width_downsizer_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             out_sat
);

  localparam int unsigned RATIO = IN_W / OUT_W;
  localparam int unsigned CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [RATIO-1:0][OUT_W-1:0]  hold_q, hold_d;
  logic [OUT_W-1:0]             out_data_q, out_data_d;
  logic                         out_valid_q, out_valid_d;
  logic                         out_last_q, out_last_d;
  logic                         out_sat_q, out_sat_d;

  logic                         in_fire, out_fire, load_word;
  logic [OUT_W-1:0]             clamp_value;
  logic                         clamp_sat;

  width_downsizer_sat_clamp #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_sat_clamp (
    .data_i    (in_data),
    .value_c_o (clamp_value),
    .sat_c_o   (clamp_sat)
  );

  // A new word may enter while idle or as the final beat of the current word leaves.
  assign in_ready = !out_valid_q || (out_ready && out_last_q);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_sat_d   = out_sat_q;
    load_word   = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_fire) load_word = 1'b1;
      end
      SEND: begin
        if (out_fire) begin
          if (!out_last_q) begin
            cnt_d      = cnt_q + CNT_W'(1);
            out_data_d = hold_q[cnt_d];
            out_last_d = (cnt_d == CNT_W'(RATIO - 1));
          end else if (in_fire) begin
            load_word = 1'b1;
          end else begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_sat_d   = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Mode only shapes beat 0; later serialize beats come from the holding register.
    if (load_word) begin
      state_d     = SEND;
      cnt_d       = '0;
      hold_d      = in_data;
      out_valid_d = 1'b1;
      out_data_d  = in_data[OUT_W-1:0];
      out_last_d  = 1'b1;
      out_sat_d   = 1'b0;
      case (mode_e'(in_mode))
        MODE_SER: out_last_d = 1'b0;
        MODE_SAT: begin
          out_data_d = clamp_value;
          out_sat_d  = clamp_sat;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_width_downsizer.sv
// Directed and randomized self-checking bench for width_downsizer (32 -> 16).
module tb_width_downsizer;

  localparam int unsigned IN_W  = 32;
  localparam int unsigned OUT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [IN_W-1:0]  in_data;
  logic [1:0]       in_mode;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             out_sat;

  int checks   = 0;
  int failures = 0;

  width_downsizer #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Packs {valid,last,sat,data} so one comparison covers the whole output beat.
  task automatic chk_beat(input string tag, input logic v, input logic l, input logic s,
                          input logic [15:0] d);
    chk(tag, {13'd0, out_valid, out_last, out_sat, out_data}, {13'd0, v, l, s, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [17:0]        exp_q[$];
  logic [17:0]        exp_b;
  logic [31:0]        snap;
  logic               stall;
  logic signed [31:0] sv;
  int                 words;
  int                 cycles;
  logic [31:0]        sat_in  [4];
  logic [17:0]        sat_exp [4];

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 2'b00;
    out_ready = 1'b0;
    tick();
    tick();
    chk_beat("reset_outputs", 1'b0, 1'b0, 1'b0, 16'h0000);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of a serialization, concurrent with a handshake
    in_valid = 1'b1; in_data = 32'hDEADBEEF; in_mode = 2'b01; out_ready = 1'b0;
    tick();
    chk_beat("rst_mid_beat0", 1'b1, 1'b0, 1'b0, 16'hBEEF);
    in_valid = 1'b0; rst = 1'b1; out_ready = 1'b1;
    tick();
    chk_beat("rst_mid_cleared", 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // Truncate, then back-to-back reserved mode (must act as truncate)
    in_valid = 1'b1; in_data = 32'h12345678; in_mode = 2'b00; out_ready = 1'b1;
    tick();
    chk_beat("trunc_beat", 1'b1, 1'b1, 1'b0, 16'h5678);
    chk("trunc_in_ready", 32'(in_ready), 32'd1);
    in_data = 32'hFFFF0000; in_mode = 2'b11;
    tick();
    chk_beat("rsvd_as_trunc", 1'b1, 1'b1, 1'b0, 16'h0000);
    in_valid = 1'b0;
    tick();
    chk("trunc_idle_valid", 32'(out_valid), 32'd0);

    // Serialize under backpressure; ignored input changes while busy
    in_valid = 1'b1; in_data = 32'hDEADBEEF; in_mode = 2'b01; out_ready = 1'b0;
    tick();
    chk_beat("ser_beat0", 1'b1, 1'b0, 1'b0, 16'hBEEF);
    in_data = 32'h11112222; in_mode = 2'b00;
    #1;
    chk("ser_in_ready_stall", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_beat($sformatf("ser_stall%0d", i), 1'b1, 1'b0, 1'b0, 16'hBEEF);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("ser_in_ready_beat0", 32'(in_ready), 32'd0);
    tick();
    chk_beat("ser_beat1", 1'b1, 1'b1, 1'b0, 16'hDEAD);
    chk("ser_in_ready_last", 32'(in_ready), 32'd1);
    tick();
    chk("ser_idle_valid", 32'(out_valid), 32'd0);

    // Saturate boundaries, streamed back to back
    sat_in[0] = 32'h00012345; sat_exp[0] = {1'b1, 1'b1, 16'h7FFF};
    sat_in[1] = 32'hFFFF0000; sat_exp[1] = {1'b1, 1'b1, 16'h8000};
    sat_in[2] = 32'hFFFF8000; sat_exp[2] = {1'b1, 1'b0, 16'h8000};
    sat_in[3] = 32'h00007FFF; sat_exp[3] = {1'b1, 1'b0, 16'h7FFF};
    in_valid = 1'b1; in_mode = 2'b10; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = sat_in[i];
      tick();
      chk_beat($sformatf("sat%0d", i), 1'b1, sat_exp[i][17], sat_exp[i][16], sat_exp[i][15:0]);
    end
    in_valid = 1'b0;
    tick();

    // Serialize followed by truncate with no bubble; mode change mid-word ignored
    in_valid = 1'b1; in_data = 32'hAAAA5555; in_mode = 2'b01; out_ready = 1'b1;
    tick();
    chk_beat("b2b_beat0", 1'b1, 1'b0, 1'b0, 16'h5555);
    in_data = 32'h0000CAFE; in_mode = 2'b00;
    tick();
    chk_beat("b2b_beat1", 1'b1, 1'b1, 1'b0, 16'hAAAA);
    tick();
    chk_beat("b2b_trunc", 1'b1, 1'b1, 1'b0, 16'hCAFE);
    in_valid = 1'b0;
    tick();
    chk("b2b_idle_valid", 32'(out_valid), 32'd0);

    // Random traffic against a beat-queue reference model
    words  = 0;
    cycles = 0;
    while (words < 10000 && cycles < 60000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = $urandom;
      in_mode   = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rand_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_b = exp_q.pop_front();
          chk("rand_beat", 32'({out_last, out_sat, out_data}), 32'(exp_b));
        end
      end
      if (in_valid && in_ready) begin
        words++;
        case (in_mode)
          2'b01: begin
            exp_q.push_back({1'b0, 1'b0, in_data[15:0]});
            exp_q.push_back({1'b1, 1'b0, in_data[31:16]});
          end
          2'b10: begin
            sv = signed'(in_data);
            if (sv > 32'sd32767)       exp_q.push_back({1'b1, 1'b1, 16'h7FFF});
            else if (sv < -32'sd32768) exp_q.push_back({1'b1, 1'b1, 16'h8000});
            else                       exp_q.push_back({1'b1, 1'b0, in_data[15:0]});
          end
          default: exp_q.push_back({1'b1, 1'b0, in_data[15:0]});
        endcase
      end
      stall = out_valid && !out_ready;
      snap  = {13'd0, out_valid, out_last, out_sat, out_data};
      tick();
      cycles++;
      if (stall) chk("rand_stall_stable", {13'd0, out_valid, out_last, out_sat, out_data}, snap);
    end
    chk("rand_word_count", 32'(words), 32'd10000);

    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) begin
      #1;
      if (out_valid) begin
        exp_b = exp_q.pop_front();
        chk("drain_beat", 32'({out_last, out_sat, out_data}), 32'(exp_b));
      end
      tick();
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_valid_low", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/width_downsizer.md
Name: width_downsizer

Overview:
Parametrised, registered width converter from an IN_W-bit producer to an OUT_W-bit consumer, with valid/ready handshakes on both sides.
It supports three per-word modes, sampled when the input word is accepted:
- truncate: keep the low OUT_W bits;
- serialize: emit the word as RATIO narrow beats, LSB first;
- saturate: signed clamp to the OUT_W range.
It sits between datapath stages of different widths, e.g. ALU result to a 16-bit bus or memory port.

Parameters:
IN_W, 32, input word width; must be an integer multiple of OUT_W.
OUT_W, 16, output beat width.
RATIO, IN_W/OUT_W, derived; number of beats in serialize mode (>= 2).
CNT_W, clog2(RATIO), derived; beat counter width.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_data  input  IN_W  input word
in_mode  input  2  00 truncate, 01 serialize, 10 saturate, 11 reserved (treated as truncate)
in_valid  input  1  producer has a word
in_ready  output  1  block accepts a word this cycle
out_data  output  OUT_W  output beat
out_valid  output  1  out_data is valid
out_ready  input  1  consumer accepts the beat
out_last  output  1  current beat is the final beat of its word
out_sat  output  1  saturate mode only: current beat was clamped

Behaviour:
- Clock and reset:
  - One clock, clk; reset is synchronous and active-high on rst. All state is updated on the rising edge of clk.
  - On rst: out_valid=0, out_last=0, out_sat=0, out_data=0, beat counter=0, state=IDLE. Any held word is discarded, including mid-serialization.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
  - in_ready = !out_valid || (out_ready && out_last). This is combinational from registered state plus out_ready and gives back-to-back throughput.
  - out_data, out_valid, out_last and out_sat are registered. Latency is 1 cycle from input acceptance to the first beat.
  - While out_valid=1 && out_ready=0, all outputs hold stable.
- State machine:
  - IDLE (out_valid=0): on input acceptance, capture in_data into the holding register, latch mode, load beat 0 and go to SEND.
  - SEND (out_valid=1):
    - Beat accepted and not last: counter++, out_data = holding[(cnt+1)*OUT_W +: OUT_W], out_last = (cnt+1 == RATIO-1).
    - Last beat accepted with a new word accepted in the same cycle: stay in SEND and load the new word's beat 0.
    - Last beat accepted with no new word: go to IDLE, out_valid=0.
- Mode rules:
  - truncate: one beat, out_data = in[OUT_W-1:0], out_last=1, out_sat=0.
  - serialize: RATIO beats. out_last=1 only on beat RATIO-1. out_sat=0.
  - saturate: treat in as signed. If in > 2^(OUT_W-1)-1, output 0x7FFF (for OUT_W=16) with out_sat=1. If in < -2^(OUT_W-1), output 0x8000 with out_sat=1. Otherwise output in[OUT_W-1:0] with out_sat=0. One beat, out_last=1.
  - Reserved mode 11 behaves exactly as truncate.
- Boundary conditions:
  - in_mode and in_data are ignored except at input acceptance. Changes during a serialization have no effect.
  - The beat counter wraps only by reload; it never exceeds RATIO-1.
  - rst asserted in the same cycle as a handshake wins: the word is dropped and out_valid=0 next cycle.
  - The producer must not be stalled by an idle consumer: in_ready=1 whenever out_valid=0.

Decomposition:
- Shared package holds the mode encodings (MODE_TRUNC=2'b00, MODE_SER=2'b01, MODE_SAT=2'b10) and the state encodings IDLE/SEND.
- One natural sub-module: sat_clamp, a combinational signed IN_W to OUT_W clamp producing value and flag, reusable elsewhere.
- Top level holds the holding register, counter, FSM and handshake logic.

Test Plan:
1. Reset and idle: assert rst mid-serialize (after beat 0 of 0xDEADBEEF, mode 01) -> next cycle out_valid=0, in_ready=1; the next word starts at beat 0.
2. Truncate: in=0x12345678, mode 00, out_ready=1 -> one cycle later out_data=0x5678, out_last=1, out_sat=0; in_ready stays 1 for a back-to-back word.
3. Serialize with backpressure: in=0xDEADBEEF, mode 01; hold out_ready=0 for 3 cycles -> out_data stays 0xBEEF. Then with out_ready=1: 0xBEEF (last=0), then 0xDEAD (last=1). in_ready=0 until the last beat is accepted.
4. Saturate: 0x00012345 -> 0x7FFF, sat=1. 0xFFFF0000 -> 0x8000, sat=1. 0xFFFF8000 -> 0x8000, sat=0. 0x00007FFF -> 0x7FFF, sat=0.
5. Back-to-back: serialize 0xAAAA5555 followed immediately by truncate 0x0000CAFE, out_ready=1 continuously -> beats 0x5555, 0xAAAA, 0xCAFE on 3 consecutive cycles with no bubble. Changing in_mode mid-word has no effect.
6. Random traffic with a reference model, random in_valid/out_ready, all modes, ≥10k words -> no lost or duplicated beats; outputs stable under stall.
